// File: rtl/mem_arb_pkg.sv
// Shared types, width defaults and helpers for the arbitrated memory.
// Imported by mem_arb_ctrl and rr_arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_NUM_CH = 2;

    // Round-robin successor of a channel index, wrapping at n.
    function automatic int next_ptr(input int cur, input int n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches upward from ptr with wrap; grant is one-hot or zero.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N = DEF_NUM_CH,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx
);

    localparam logic [W:0] NV = (W + 1)'(N);

    logic [W:0]   sum;
    logic [W-1:0] idx;
    logic         found;

    // Pick the first requester at or above ptr, wrapping past N-1.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (W + 1)'(k);
            if (sum >= NV) begin
                sum = sum - NV;
            end
            idx = sum[W-1:0];
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/mem_arb_ctrl.sv
// Round-robin arbitrated single-port scratch memory.
// One outstanding transaction: IDLE -> ACCESS -> RESP -> IDLE.
module mem_arb_ctrl
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_CH = DEF_NUM_CH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        req_valid,
    output logic [NUM_CH-1:0]        req_ready,
    input  logic [NUM_CH-1:0]        req_write,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH*DATA_W-1:0] req_wdata,
    output logic [NUM_CH-1:0]        rsp_valid,
    input  logic [NUM_CH-1:0]        rsp_ready,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_write,
    output logic                     busy
);

    localparam int PW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DEPTH = 1 << ADDR_W;

    state_t              state;
    state_t              state_nx;
    logic [PW-1:0]       ptr;
    logic [PW-1:0]       ch;
    logic                op_wr;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [NUM_CH-1:0]   grant;
    logic [PW-1:0]       gidx;
    logic                accept;
    logic                rsp_hs;
    logic [DATA_W-1:0]   mem [DEPTH];

    rr_arbiter #(
        .N (NUM_CH),
        .W (PW)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (gidx)
    );

    // Next state, grant exposure and busy flag.
    always_comb begin
        state_nx  = state;
        req_ready = '0;
        busy      = (state != IDLE);
        accept    = 1'b0;
        rsp_hs    = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = grant;
                accept    = |grant;
                if (accept) begin
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                state_nx = RESP;
            end
            RESP: begin
                rsp_hs = rsp_ready[ch];
                if (rsp_hs) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Capture the granted request at the accept edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch      <= '0;
            op_wr   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            ch      <= gidx;
            op_wr   <= req_write[gidx];
            addr_q  <= req_addr[int'(gidx)*ADDR_W +: ADDR_W];
            wdata_q <= req_wdata[int'(gidx)*DATA_W +: DATA_W];
        end
    end

    // Storage write; reset at the access edge blocks it.
    always_ff @(posedge clk) begin
        if (!rst && state == ACCESS && op_wr) begin
            mem[addr_q] <= wdata_q;
        end
    end

    // Response payload, loaded in ACCESS and held through RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_rdata <= '0;
            rsp_write <= 1'b0;
        end else if (state == ACCESS) begin
            rsp_rdata <= op_wr ? '0 : mem[addr_q];
            rsp_write <= op_wr;
        end
    end

    // Per-channel response valid, cleared on the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= '0;
        end else if (state == ACCESS) begin
            rsp_valid <= NUM_CH'(1) << ch;
        end else if (rsp_hs) begin
            rsp_valid <= '0;
        end
    end

    // Round-robin pointer advances past the channel just served.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (rsp_hs) begin
            ptr <= PW'(next_ptr(int'(ch), NUM_CH));
        end
    end

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Randomized bench for mem_arb_ctrl with a transaction-level model.
// Three channels exercise non power-of-two pointer wrap.
module tb_mem_arb_ctrl;

    localparam int AW    = 5;
    localparam int DW    = 8;
    localparam int NCH   = 3;
    localparam int DEPTH = 32;
    localparam int NCYC  = 4000;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NCH-1:0]        req_valid;
    logic [NCH-1:0]        req_ready;
    logic [NCH-1:0]        req_write;
    logic [NCH*AW-1:0]     req_addr;
    logic [NCH*DW-1:0]     req_wdata;
    logic [NCH-1:0]        rsp_valid;
    logic [NCH-1:0]        rsp_ready;
    logic [DW-1:0]         rsp_rdata;
    logic                  rsp_write;
    logic                  busy;

    mem_arb_ctrl #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .NUM_CH (NCH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_write (rsp_write),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    // Pending request per channel, held until accepted.
    bit pv [NCH];
    bit pw [NCH];
    int pa [NCH];
    int pd [NCH];

    // Reference: memory, outstanding transaction, arbitration pointer.
    int ref_mem [DEPTH];
    bit known   [DEPTH];
    bit mbusy;
    int mptr;
    int mch;
    int phase;
    bit m_wr;
    int m_addr;
    int m_wdata;
    int exp_rd;
    bit exp_wr;
    bit rd_known;
    bit post_rst;
    int g;
    int n_done;
    int r;

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = '0;
        mbusy     = 0;
        mptr      = 0;
        mch       = 0;
        phase     = 0;
        post_rst  = 1;
        n_done    = 0;
        rd_known  = 0;
        exp_rd    = 0;
        exp_wr    = 0;
        for (int i = 0; i < DEPTH; i++) begin
            known[i]   = 0;
            ref_mem[i] = 0;
        end
        for (int c = 0; c < NCH; c++) begin
            pv[c] = 0;
            pw[c] = 0;
            pa[c] = 0;
            pd[c] = 0;
        end

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            rst = (cyc < 2)
                || (mbusy && phase == 1 && m_wr && $urandom_range(0, 3) == 0)
                || ($urandom_range(0, 99) == 0);
            for (int c = 0; c < NCH; c++) begin
                if (!pv[c] && $urandom_range(0, 2) != 0) begin
                    pv[c] = 1;
                    if (cyc < 400) pw[c] = ($urandom_range(0, 3) != 0);
                    else           pw[c] = ($urandom_range(0, 1) != 0);
                    r = $urandom_range(0, 9);
                    if (r == 0)      pa[c] = 0;
                    else if (r == 1) pa[c] = DEPTH - 1;
                    else             pa[c] = $urandom_range(0, DEPTH - 1);
                    pd[c] = $urandom_range(0, 255);
                end
                req_valid[c]           = pv[c];
                req_write[c]           = pw[c];
                req_addr[c*AW +: AW]   = AW'(pa[c]);
                req_wdata[c*DW +: DW]  = DW'(pd[c]);
                rsp_ready[c]           = ($urandom_range(0, 2) != 0);
            end

            @(negedge clk);
            if (post_rst) begin
                check("rst_rdata", 32'(rsp_rdata), 32'd0);
                check("rst_rwrite", 32'(rsp_write), 32'd0);
            end
            g = -1;
            if (!mbusy) begin
                for (int k = 0; k < NCH; k++) begin
                    if (g < 0 && pv[(mptr + k) % NCH]) g = (mptr + k) % NCH;
                end
                check("idle_ready", 32'(req_ready),
                      (g >= 0) ? (32'd1 << g) : 32'd0);
                check("idle_rvalid", 32'(rsp_valid), 32'd0);
                check("idle_busy", 32'(busy), 32'd0);
            end else begin
                check("busy_ready", 32'(req_ready), 32'd0);
                check("busy_busy", 32'(busy), 32'd1);
                if (phase >= 2) begin
                    check("rsp_valid", 32'(rsp_valid), 32'd1 << mch);
                    check("rsp_write", 32'(rsp_write), 32'(exp_wr));
                    if (rd_known)
                        check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
                end else begin
                    check("acc_rvalid", 32'(rsp_valid), 32'd0);
                end
            end

            post_rst = rst;
            if (rst) begin
                mbusy = 0;
                mptr  = 0;
            end else if (!mbusy) begin
                if (g >= 0) begin
                    mbusy   = 1;
                    mch     = g;
                    phase   = 1;
                    m_wr    = pw[g];
                    m_addr  = pa[g];
                    m_wdata = pd[g];
                    pv[g]   = 0;
                end
            end else if (phase == 1) begin
                if (m_wr) begin
                    ref_mem[m_addr] = m_wdata;
                    known[m_addr]   = 1;
                    exp_rd          = 0;
                    exp_wr          = 1;
                    rd_known        = 1;
                end else begin
                    exp_rd   = ref_mem[m_addr];
                    rd_known = known[m_addr];
                    exp_wr   = 0;
                end
                phase = 2;
            end else if (rsp_ready[mch]) begin
                mbusy = 0;
                mptr  = (mch + 1) % NCH;
                n_done++;
            end
        end

        check("progress", 32'(n_done > 200), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
                 n_err);
        $finish;
    end

endmodule
